// File: rtl/lsu_handshake.sv
// lsu_handshake: load/store unit sitting between the MEM stage and a
// variable-latency data memory. One access at a time: the request is
// captured in IDLE, held on the memory port during WAIT, and reported
// with a one-cycle response pulse in RESP.
module lsu_handshake #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Req_valid_i,
    input  logic                Req_we_i,
    input  logic [1:0]          Req_size_i,
    input  logic                Req_unsigned_i,
    input  logic [ADDR_W-1:0]   Req_addr_i,
    input  logic [XLEN-1:0]     Req_wdata_i,
    input  logic [4:0]          Req_rd_i,
    output logic                Busy_o,
    output logic                Resp_valid_o,
    output logic                Resp_wb_we_o,
    output logic [4:0]          Resp_rd_o,
    output logic [XLEN-1:0]     Resp_data_o,
    output logic                Err_misalign_o,
    output logic                Err_timeout_o,
    output logic                Dmem_req_o,
    output logic                Dmem_we_o,
    output logic [XLEN/8-1:0]   Dmem_be_o,
    output logic [ADDR_W-1:0]   Dmem_addr_o,
    output logic [XLEN-1:0]     Dmem_wdata_o,
    input  logic                Dmem_ack_i,
    input  logic [XLEN-1:0]     Dmem_rdata_i
);

    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);
    // The counter only has to reach TIMEOUT_CYC-1, so clog2(TIMEOUT_CYC) bits suffice.
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Captured request fields, held for the whole access
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [LANE_W-1:0]   lane_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [NB-1:0]       be_q;
    logic [XLEN-1:0]     wdata_q;
    logic [4:0]          rd_q;

    // Registered response outputs (zero except in their pulse cycle)
    logic                resp_valid_q, resp_valid_d;
    logic                resp_wb_we_q, resp_wb_we_d;
    logic [4:0]          resp_rd_q, resp_rd_d;
    logic [XLEN-1:0]     resp_data_q, resp_data_d;
    logic                err_mis_q, err_mis_d;
    logic                err_to_q, err_to_d;

    logic                accept;
    logic [LANE_W-1:0]   req_lane;
    logic                misalign;
    logic [NB-1:0]       be_base;
    logic [NB-1:0]       req_be;
    logic [XLEN-1:0]     req_wdata;
    logic [XLEN-1:0]     rd_shift;
    logic [XLEN-1:0]     ext_mask;
    logic                ext_sign;
    logic [XLEN-1:0]     load_ext;

    // Decode the incoming request: alignment check, byte enables and lane-positioned store data
    always_comb begin
        req_lane = Req_addr_i[LANE_W-1:0];
        misalign = 1'b0;
        be_base  = '1;
        case (Req_size_i)
            2'd0: be_base = NB'(1);
            2'd1: begin
                be_base  = NB'(3);
                misalign = Req_addr_i[0];
            end
            2'd2: begin
                be_base  = NB'(15);
                misalign = |Req_addr_i[1:0];
            end
            default: begin
                be_base  = '1;
                misalign = (XLEN == 32) || (|Req_addr_i[2:0]);
            end
        endcase
        req_be    = be_base << req_lane;
        req_wdata = Req_wdata_i << {req_lane, 3'b000};
    end

    // Pull the addressed lane down to bit 0 and extend it to full width
    always_comb begin
        rd_shift = Dmem_rdata_i >> {lane_q, 3'b000};
        ext_mask = '1;
        ext_sign = rd_shift[XLEN-1];
        case (size_q)
            2'd0: begin
                ext_mask = XLEN'(8'hFF);
                ext_sign = rd_shift[7];
            end
            2'd1: begin
                ext_mask = XLEN'(16'hFFFF);
                ext_sign = rd_shift[15];
            end
            2'd2: begin
                ext_mask = XLEN'(32'hFFFF_FFFF);
                ext_sign = rd_shift[31];
            end
            default: begin
                ext_mask = '1;
                ext_sign = rd_shift[XLEN-1];
            end
        endcase
        load_ext = (rd_shift & ext_mask) | (~ext_mask & {XLEN{ext_sign & ~uns_q}});
    end

    // Next-state logic; an ack arriving on the expiry cycle takes priority over the timeout
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        resp_valid_d = 1'b0;
        resp_wb_we_d = 1'b0;
        resp_rd_d    = 5'd0;
        resp_data_d  = '0;
        err_mis_d    = 1'b0;
        err_to_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req_valid_i) begin
                    if (misalign) begin
                        resp_valid_d = 1'b1;
                        err_mis_d    = 1'b1;
                        resp_rd_d    = Req_rd_i;
                    end else begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (Dmem_ack_i) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    if (!we_q) begin
                        resp_wb_we_d = 1'b1;
                        resp_data_d  = load_ext;
                    end
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    err_to_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, timeout counter, captured request and response registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            lane_q       <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            rd_q         <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_wb_we_q <= 1'b0;
            resp_rd_q    <= 5'd0;
            resp_data_q  <= '0;
            err_mis_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_wb_we_q <= resp_wb_we_d;
            resp_rd_q    <= resp_rd_d;
            resp_data_q  <= resp_data_d;
            err_mis_q    <= err_mis_d;
            err_to_q     <= err_to_d;
            if (accept) begin
                we_q    <= Req_we_i;
                size_q  <= Req_size_i;
                uns_q   <= Req_unsigned_i;
                lane_q  <= req_lane;
                addr_q  <= {Req_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                be_q    <= req_be;
                wdata_q <= req_wdata;
                rd_q    <= Req_rd_i;
            end
        end
    end

    // Memory port is driven only while waiting, so it reads as zero in IDLE/RESP and after reset
    always_comb begin
        Dmem_req_o   = (state_q == S_WAIT);
        Dmem_we_o    = Dmem_req_o & we_q;
        Dmem_be_o    = Dmem_req_o ? be_q    : '0;
        Dmem_addr_o  = Dmem_req_o ? addr_q  : '0;
        Dmem_wdata_o = Dmem_req_o ? wdata_q : '0;
    end

    assign Busy_o         = (state_q != S_IDLE);
    assign Resp_valid_o   = resp_valid_q;
    assign Resp_wb_we_o   = resp_wb_we_q;
    assign Resp_rd_o      = resp_rd_q;
    assign Resp_data_o    = resp_data_q;
    assign Err_misalign_o = err_mis_q;
    assign Err_timeout_o  = err_to_q;

endmodule

// File: tb/tb_lsu_handshake.sv
// tb_lsu_handshake: directed bench for lsu_handshake. Two instances: a 32-bit
// unit with the default timeout and a 64-bit unit with a short timeout of 4.
// Shared request/ack signals are steered to one unit at a time by sel64.
module tb_lsu_handshake;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        sel64;
    logic        req_valid, req_we, req_uns, ack;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, rdata;
    logic [4:0]  req_rd;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int busyCount;
    int reqCount;
    int stray;
    logic [5:0] expReq;
    logic [5:0] expResp;

    logic        a_busy, a_resp_valid, a_wb_we, a_err_mis, a_err_to, a_dreq, a_dwe;
    logic [4:0]  a_rd;
    logic [31:0] a_data, a_daddr, a_dwdata;
    logic [3:0]  a_be;

    logic        b_busy, b_resp_valid, b_wb_we, b_err_mis, b_err_to, b_dreq, b_dwe;
    logic [4:0]  b_rd;
    logic [63:0] b_data, b_dwdata;
    logic [31:0] b_daddr;
    logic [7:0]  b_be;

    always #5 Clk = ~Clk;

    lsu_handshake #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(255)) dut32 (
        .Clk(Clk), .Reset(Reset),
        .Req_valid_i(req_valid & ~sel64), .Req_we_i(req_we), .Req_size_i(req_size),
        .Req_unsigned_i(req_uns), .Req_addr_i(req_addr), .Req_wdata_i(req_wdata[31:0]),
        .Req_rd_i(req_rd),
        .Busy_o(a_busy), .Resp_valid_o(a_resp_valid), .Resp_wb_we_o(a_wb_we),
        .Resp_rd_o(a_rd), .Resp_data_o(a_data),
        .Err_misalign_o(a_err_mis), .Err_timeout_o(a_err_to),
        .Dmem_req_o(a_dreq), .Dmem_we_o(a_dwe), .Dmem_be_o(a_be),
        .Dmem_addr_o(a_daddr), .Dmem_wdata_o(a_dwdata),
        .Dmem_ack_i(ack & ~sel64), .Dmem_rdata_i(rdata[31:0])
    );

    lsu_handshake #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(4)) dut64 (
        .Clk(Clk), .Reset(Reset),
        .Req_valid_i(req_valid & sel64), .Req_we_i(req_we), .Req_size_i(req_size),
        .Req_unsigned_i(req_uns), .Req_addr_i(req_addr), .Req_wdata_i(req_wdata),
        .Req_rd_i(req_rd),
        .Busy_o(b_busy), .Resp_valid_o(b_resp_valid), .Resp_wb_we_o(b_wb_we),
        .Resp_rd_o(b_rd), .Resp_data_o(b_data),
        .Err_misalign_o(b_err_mis), .Err_timeout_o(b_err_to),
        .Dmem_req_o(b_dreq), .Dmem_we_o(b_dwe), .Dmem_be_o(b_be),
        .Dmem_addr_o(b_daddr), .Dmem_wdata_o(b_dwdata),
        .Dmem_ack_i(ack & sel64), .Dmem_rdata_i(rdata)
    );

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] check %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one request for a cycle (optionally leave valid high), return in the following cycle
    task automatic applyStimulus(input logic use64, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [63:0] wdata,
                                 input logic [4:0] rd, input logic hold);
        sel64     = use64;
        req_we    = we;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        req_valid = 1'b1;
        @(negedge Clk);
        req_valid = hold;
    endtask

    initial begin
        Reset = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_uns = 1'b0;
        ack = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0; rdata = '0; req_rd = '0;

        // Reset state
        @(negedge Clk);
        checkOutput("rst_busy32", a_busy, 0);
        checkOutput("rst_dreq32", a_dreq, 0);
        checkOutput("rst_resp32", a_resp_valid, 0);
        checkOutput("rst_busy64", b_busy, 0);
        checkOutput("rst_be64", b_be, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // SB 0x1003, ack in the first WAIT cycle
        applyStimulus(0, 1, 2'd0, 0, 32'h1003, 64'hA5, 5'd5, 0);
        checkOutput("sb_dreq", a_dreq, 1);
        checkOutput("sb_dwe", a_dwe, 1);
        checkOutput("sb_addr", a_daddr, 32'h1000);
        checkOutput("sb_be", a_be, 4'b1000);
        checkOutput("sb_wdata", a_dwdata, 32'hA500_0000);
        ack = 1'b1;
        @(negedge Clk);
        ack = 1'b0;
        checkOutput("sb_resp_valid", a_resp_valid, 1);
        checkOutput("sb_wb_we", a_wb_we, 0);
        checkOutput("sb_data", a_data, 0);
        checkOutput("sb_rd", a_rd, 5);
        checkOutput("sb_dreq_drop", a_dreq, 0);
        @(negedge Clk);
        checkOutput("sb_resp_pulse_end", a_resp_valid, 0);
        checkOutput("sb_idle", a_busy, 0);

        // LH 0x2002, ack in the fifth WAIT cycle
        applyStimulus(0, 0, 2'd1, 0, 32'h2002, 64'h0, 5'd7, 0);
        checkOutput("lh_be", a_be, 4'b1100);
        checkOutput("lh_addr", a_daddr, 32'h2000);
        busyCount = 0;
        for (int c = 1; c <= 8; c++) begin
            busyCount += a_busy;
            if (c == 5) checkOutput("lh_no_early_resp", a_resp_valid, 0);
            if (c == 6) begin
                checkOutput("lh_resp_valid", a_resp_valid, 1);
                checkOutput("lh_data", a_data, 32'hFFFF_8001);
                checkOutput("lh_wb_we", a_wb_we, 1);
                checkOutput("lh_rd", a_rd, 7);
            end
            if (c == 5) begin
                ack = 1'b1;
                rdata = 64'h8001_1234;
            end
            @(negedge Clk);
            ack = 1'b0;
        end
        checkOutput("lh_busy_cycles", busyCount, 6);

        // LBU 0x2001
        applyStimulus(0, 0, 2'd0, 1, 32'h2001, 64'h0, 5'd9, 0);
        checkOutput("lbu_be", a_be, 4'b0010);
        ack = 1'b1;
        rdata = 64'h0000_F000;
        @(negedge Clk);
        ack = 1'b0;
        checkOutput("lbu_data", a_data, 32'h0000_00F0);
        checkOutput("lbu_wb_we", a_wb_we, 1);
        @(negedge Clk);

        // Misaligned LW 0x3002: no memory access, immediate error response
        applyStimulus(0, 0, 2'd2, 0, 32'h3002, 64'h0, 5'd4, 0);
        checkOutput("lw_mis_err", a_err_mis, 1);
        checkOutput("lw_mis_resp", a_resp_valid, 1);
        checkOutput("lw_mis_wb_we", a_wb_we, 0);
        checkOutput("lw_mis_busy", a_busy, 0);
        checkOutput("lw_mis_dreq", a_dreq, 0);
        @(negedge Clk);
        checkOutput("lw_mis_err_end", a_err_mis, 0);
        checkOutput("lw_mis_dreq_after", a_dreq, 0);

        // Misaligned LH 0x3001
        applyStimulus(0, 0, 2'd1, 0, 32'h3001, 64'h0, 5'd4, 0);
        checkOutput("lh_mis_err", a_err_mis, 1);
        checkOutput("lh_mis_dreq", a_dreq, 0);
        @(negedge Clk);

        // SD on a 32-bit unit is always misaligned
        applyStimulus(0, 1, 2'd3, 0, 32'h3000, 64'h0, 5'd2, 0);
        checkOutput("sd32_err", a_err_mis, 1);
        checkOutput("sd32_resp", a_resp_valid, 1);
        checkOutput("sd32_busy", a_busy, 0);
        checkOutput("sd32_dreq", a_dreq, 0);
        @(negedge Clk);

        // 64-bit, timeout 4: no ack gives an error after four WAIT cycles
        applyStimulus(1, 0, 2'd2, 0, 32'h10, 64'h0, 5'd6, 0);
        reqCount = 0;
        for (int c = 1; c <= 6; c++) begin
            reqCount += b_dreq;
            if (c == 4) checkOutput("to_not_yet", b_err_to, 0);
            if (c == 5) begin
                checkOutput("to_err", b_err_to, 1);
                checkOutput("to_resp", b_resp_valid, 1);
                checkOutput("to_wb_we", b_wb_we, 0);
                checkOutput("to_rd", b_rd, 6);
            end
            if (c == 6) checkOutput("to_idle", b_busy, 0);
            @(negedge Clk);
        end
        checkOutput("to_req_cycles", reqCount, 4);

        // Ack on the expiry cycle wins: LW 0x14, upper word sign-extended
        applyStimulus(1, 0, 2'd2, 0, 32'h14, 64'h0, 5'd11, 0);
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) begin
                checkOutput("lw64_be", b_be, 8'hF0);
                checkOutput("lw64_addr", b_daddr, 32'h10);
            end
            if (c == 5) begin
                checkOutput("lw64_resp", b_resp_valid, 1);
                checkOutput("lw64_no_to", b_err_to, 0);
                checkOutput("lw64_wb_we", b_wb_we, 1);
                checkOutput("lw64_data", b_data, 64'hFFFF_FFFF_89AB_CDEF);
                checkOutput("lw64_rd", b_rd, 11);
            end
            if (c == 4) begin
                ack = 1'b1;
                rdata = 64'h89AB_CDEF_0000_0000;
            end
            @(negedge Clk);
            ack = 1'b0;
        end

        // Reset during WAIT abandons the access
        applyStimulus(1, 0, 2'd3, 0, 32'h8, 64'h0, 5'd3, 0);
        checkOutput("ld_be", b_be, 8'hFF);
        checkOutput("ld_addr", b_daddr, 32'h8);
        checkOutput("ld_dreq", b_dreq, 1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checkOutput("rstw_busy", b_busy, 0);
        checkOutput("rstw_dreq", b_dreq, 0);
        checkOutput("rstw_be", b_be, 0);
        checkOutput("rstw_addr", b_daddr, 0);
        checkOutput("rstw_resp", b_resp_valid, 0);
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            stray += b_resp_valid + b_err_to + b_dreq;
        end
        checkOutput("rstw_no_late_activity", stray, 0);

        // Back-to-back LD with valid and ack held high
        ack = 1'b1;
        rdata = 64'h1122_3344_5566_7788;
        expReq  = 6'b001001;
        expResp = 6'b010010;
        applyStimulus(1, 0, 2'd3, 0, 32'h8, 64'h0, 5'd9, 1);
        for (int c = 1; c <= 6; c++) begin
            checkOutput($sformatf("b2b_dreq_c%0d", c), b_dreq, expReq[c-1]);
            checkOutput($sformatf("b2b_resp_c%0d", c), b_resp_valid, expResp[c-1]);
            if (c == 2 || c == 5) checkOutput($sformatf("b2b_data_c%0d", c), b_data, 64'h1122_3344_5566_7788);
            @(negedge Clk);
        end
        req_valid = 1'b0;
        ack = 1'b0;
        repeat (8) @(negedge Clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lsu_handshake.md
Name: lsu_handshake

Overview:
- Parametrised load/store unit replacing the ideal single-cycle data-memory path of the RV32i pipeline.
- Accepts one load/store from the MEM stage and drives a req/ack handshake to a data memory with variable latency.
- Generates byte enables, lane-shifted write data and sign/zero-extended load data, plus misalignment and timeout errors.
- Asserts Busy_o so the stall controller freezes the pipeline while an access is outstanding.

Parameters:
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 32: byte address width.
- TIMEOUT_CYC, 255: cycles to wait for Dmem_ack_i before aborting; 0 disables the timeout.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- Req_valid_i  in  1  access request from MEM stage
- Req_we_i  in  1  1=store, 0=load
- Req_size_i  in  2  0=byte, 1=half, 2=word, 3=double (legal only when XLEN=64)
- Req_unsigned_i  in  1  zero-extend load (LBU/LHU/LWU)
- Req_addr_i  in  ADDR_W  byte address
- Req_wdata_i  in  XLEN  store data, right-aligned
- Req_rd_i  in  5  destination register
- Busy_o  out  1  access in progress; pipeline stall
- Resp_valid_o  out  1  one-cycle completion pulse
- Resp_wb_we_o  out  1  writeback enable; valid with Resp_valid_o
- Resp_rd_o  out  5  destination register
- Resp_data_o  out  XLEN  extended load data
- Err_misalign_o  out  1  one-cycle pulse
- Err_timeout_o  out  1  one-cycle pulse
- Dmem_req_o  out  1  memory request
- Dmem_we_o  out  1  memory write
- Dmem_be_o  out  XLEN/8  byte enables
- Dmem_addr_o  out  ADDR_W  address, low log2(XLEN/8) bits forced to 0
- Dmem_wdata_o  out  XLEN  lane-positioned write data
- Dmem_ack_i  in  1  memory completion; for loads, rdata is valid in the same cycle
- Dmem_rdata_i  in  XLEN  full aligned word read

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0. Reset mid-access abandons it: no response and no error pulse, Dmem_req_o drops the next cycle.
- States:
  - IDLE: Busy_o=0. Samples Req_valid_i.
  - WAIT: Busy_o=1; Dmem_req_o=1.
  - RESP: Busy_o=1; Resp_valid_o=1 for exactly one cycle; then back to IDLE.
- Request acceptance: only in IDLE; Req_valid_i outside IDLE is ignored. Let lane = Req_addr_i[log2(XLEN/8)-1:0].
- Misaligned request: size 1 with addr[0]=1, size 2 with addr[1:0]!=0, size 3 with addr[2:0]!=0, or size 3 with XLEN=32.
  - Next cycle: Err_misalign_o=1, Resp_valid_o=1, Resp_wb_we_o=0.
  - No memory access is made; stays IDLE (Busy_o stays 0).
- Aligned request: registers all fields and enters WAIT next cycle.
  - Dmem_be_o = ((1<<(1<<size))-1) << lane.
  - Dmem_wdata_o = Req_wdata_i << (8*lane).
  - All Dmem_* outputs are held stable for the whole of WAIT.
- WAIT with Dmem_ack_i=1:
  - Load: Dmem_rdata_i >> (8*lane) is captured, truncated to the access size, then sign-extended (or zero-extended if Req_unsigned_i) to XLEN.
  - Go to RESP; Dmem_req_o deasserts in the same transition.
- RESP outputs:
  - Load: Resp_wb_we_o=1, Resp_data_o = extended data.
  - Store: Resp_wb_we_o=0, Resp_data_o=0.
  - Resp_rd_o = the registered rd.
- Minimum latency: accept at cycle 0, Dmem_req_o at cycle 1, ack at cycle 1, Resp_valid_o at cycle 2. Throughput is one access per 3 cycles at best.
- Timeout counter: cleared on entry to WAIT; increments every WAIT cycle without ack.
  - If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 without ack: go to RESP with Err_timeout_o=1 and Resp_wb_we_o=0.
  - Ack arriving in the same cycle as expiry wins: normal completion, no error.
- Rd=0 is not special-cased; the register file discards writes to x0.

Test Plan:
- Byte store: XLEN=32, SB addr 0x1003, wdata 0x000000A5 -> Dmem_addr_o=0x1000, Dmem_be_o=4'b1000, Dmem_wdata_o=0xA5000000; ack at cycle 1 gives Resp_valid_o at cycle 2 with Resp_wb_we_o=0.
- Signed halfword load: LH addr 0x2002, rdata 0x8001_1234, ack delayed 5 cycles -> Busy_o high for 6 cycles, Resp_data_o=0xFFFF8001, Resp_wb_we_o=1, rd echoed.
- Unsigned byte load: LBU addr 0x2001, rdata 0x0000_F000 -> Resp_data_o=0x000000F0.
- Misaligned access: LW addr 0x3002 -> no Dmem_req_o, Err_misalign_o and Resp_valid_o pulse next cycle, Busy_o stays 0. SD with XLEN=32 behaves the same.
- Timeout: TIMEOUT_CYC=4, no ack -> Err_timeout_o after 4 WAIT cycles, Resp_wb_we_o=0. Ack on the 4th cycle -> normal load response, no error.
- Reset and back-to-back, XLEN=64:
  - Reset asserted during WAIT -> all outputs 0 next cycle, no Resp_valid_o.
  - Back-to-back requests with Req_valid_i held high -> the second is accepted only after RESP.
  - LD addr 0x8 -> Dmem_be_o=8'hFF.
